// File: rtl/rv32im_mul_ctrl.sv
// rtl/rv32im_mul_ctrl.sv - RV32IM multiply sign-handling front end for the shift-add core
// Converts signed operands to magnitudes, launches the core and sign-corrects the product.
module rv32im_mul_ctrl #(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [XLEN-1:0]     result_o,
    output logic                mul_start_o,
    output logic [XLEN-1:0]     mul_op1_o,
    output logic [XLEN-1:0]     mul_op2_o,
    input  logic                mul_valid_i,
    input  logic [2*XLEN-1:0]   mul_product_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state;
    logic [1:0]          op_sel;
    logic                neg;
    logic [2*XLEN-1:0]   p;

    logic                sgn1;
    logic                sgn2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic [2*XLEN-1:0]   p_fix;
    logic [XLEN-1:0]     result_sel;

    // Only MULH treats rs2 as signed; MULH and MULHSU treat rs1 as signed.
    always_comb begin
        sgn1       = rs1_i[XLEN-1] & ((funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10));
        sgn2       = rs2_i[XLEN-1] & (funct3_i[1:0] == 2'b01);
        mag1       = sgn1 ? (~rs1_i + 1'b1) : rs1_i;
        mag2       = sgn2 ? (~rs2_i + 1'b1) : rs2_i;
        p_fix      = neg ? (~p + 1'b1) : p;
        result_sel = (op_sel == 2'b00) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
    end

    assign ready_o = (state == S_IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            op_sel      <= 2'b00;
            neg         <= 1'b0;
            p           <= '0;
            done_o      <= 1'b0;
            result_o    <= '0;
            mul_start_o <= 1'b0;
            mul_op1_o   <= '0;
            mul_op2_o   <= '0;
        end else begin
            done_o      <= 1'b0;
            mul_start_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_i && !funct3_i[2]) begin
                        op_sel      <= funct3_i[1:0];
                        neg         <= sgn1 ^ sgn2;
                        mul_op1_o   <= mag1;
                        mul_op2_o   <= mag2;
                        mul_start_o <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_valid_i) begin
                        p     <= mul_product_i;
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Correction and half-select land together so done_o rises in DONE.
                    p        <= p_fix;
                    result_o <= result_sel;
                    done_o   <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32im_mul_ctrl.sv
// tb/tb_rv32im_mul_ctrl.sv - directed-vector bench for rv32im_mul_ctrl
// Includes a behavioural 32-cycle shift-add core stand-in driven from the bench.
module tb_rv32im_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        mul_start;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic        mul_valid = 1'b0;
    logic [63:0] mul_product = '0;

    int vectors = 0;
    int miscompares = 0;

    rv32im_mul_ctrl #(.XLEN(32)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_i         (req),
        .funct3_i      (funct3),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .ready_o       (ready),
        .done_o        (done),
        .result_o      (result),
        .mul_start_o   (mul_start),
        .mul_op1_o     (mul_op1),
        .mul_op2_o     (mul_op2),
        .mul_valid_i   (mul_valid),
        .mul_product_i (mul_product)
    );

    always #5 clk = ~clk;

    // Issues one request and plays the core: valid arrives 33 cycles after start.
    // Cycle 1 is the cycle right after the accept edge. Returns at the start of the
    // cycle after done_o (or after cycle 40 when extra busy requests are injected).
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit extra, output int done_c, output int ndone,
                          output int start_c, output int nstart, output logic [31:0] res,
                          output logic [31:0] op1, output logic [31:0] op2);
        logic [63:0] prod;
        int c;
        done_c = -1; ndone = 0; start_c = -1; nstart = 0;
        res = '0; op1 = '0; op2 = '0; prod = '0;
        @(negedge clk);
        req = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        @(posedge clk);
        c = 1;
        while (c <= 80 && !(extra ? (c > 40) : (ndone > 0))) begin
            @(negedge clk);
            req = extra && (c == 5 || c == 20);
            if (mul_start) begin
                nstart++;
                start_c = c;
                op1 = mul_op1;
                op2 = mul_op2;
                prod = {32'b0, mul_op1} * {32'b0, mul_op2};
            end
            mul_valid = (start_c > 0) && (c == start_c + 33);
            mul_product = mul_valid ? prod : 64'hDEAD_BEEF_0BAD_F00D;
            if (done) begin
                ndone++;
                done_c = c;
                res = result;
            end
            @(posedge clk);
            c++;
        end
        #1;
        req = 1'b0;
        mul_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({ready, done, mul_start} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready/done/start=%b required 100", {ready, done, mul_start});
        end
        vectors++;
        if (mul_op1 !== 32'h0 || mul_op2 !== 32'h0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: op1=%h op2=%h result=%h required all 0", mul_op1, mul_op2, result);
        end
    endtask

    task automatic test_mul_timing();
        int dc, nd, sc, ns;
        logic [31:0] r, o1, o2;
        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mul_result: got %h required FFFFFFEB", r);
        end
        vectors++;
        if (dc !== 36) begin
            miscompares++;
            $display("FAIL mul_latency: done in cycle %0d required 36", dc);
        end
        vectors++;
        if (ns !== 1 || sc !== 1) begin
            miscompares++;
            $display("FAIL mul_start: %0d pulses, first in cycle %0d, required 1 pulse in cycle 1", ns, sc);
        end
        vectors++;
        if (o1 !== 32'h0000_0007 || o2 !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL mul_operands: op1=%h op2=%h required 00000007 FFFFFFFD", o1, o2);
        end
    endtask

    task automatic test_mulh();
        int dc, nd, sc, ns;
        logic [31:0] r, o1, o2;
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (o1 !== 32'h8000_0000 || o2 !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL mulh_min_operands: op1=%h op2=%h required 80000000 80000000", o1, o2);
        end
        vectors++;
        if (r !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL mulh_min_result: got %h required 40000000", r);
        end
        run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'hFFFF_FFFF || o1 !== 32'h1 || o2 !== 32'h2) begin
            miscompares++;
            $display("FAIL mulh_neg: result=%h op1=%h op2=%h required FFFFFFFF 00000001 00000002", r, o1, o2);
        end
        run_op(3'b001, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'h0000_0000 || o1 !== 32'h5) begin
            miscompares++;
            $display("FAIL mulh_neg_zero: result=%h op1=%h required 00000000 00000005", r, o1);
        end
    endtask

    task automatic test_all_ones();
        int dc, nd, sc, ns;
        logic [31:0] r, o1, o2;
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'hFFFF_FFFF || o1 !== 32'h1 || o2 !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL mulhsu_ones: result=%h op1=%h op2=%h required FFFFFFFF 00000001 FFFFFFFF", r, o1, o2);
        end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL mulhu_ones: got %h required FFFFFFFE", r);
        end
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL mul_ones: got %h required 00000001", r);
        end
    endtask

    task automatic test_busy_requests();
        int dc, nd, sc, ns;
        logic [31:0] r, o1, o2;
        run_op(3'b011, 32'h0001_0000, 32'h0003_0000, 1'b1, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (nd !== 1 || ns !== 1 || dc !== 36) begin
            miscompares++;
            $display("FAIL busy_ignore: dones=%0d starts=%0d done_cycle=%0d required 1 1 36", nd, ns, dc);
        end
        vectors++;
        if (r !== 32'h0000_0003) begin
            miscompares++;
            $display("FAIL busy_result: got %h required 00000003", r);
        end
    endtask

    task automatic test_illegal_funct3();
        int starts = 0;
        int not_ready = 0;
        @(negedge clk);
        req = 1'b1; funct3 = 3'b100; rs1 = 32'h5; rs2 = 32'h6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mul_start) starts++;
            if (!ready) not_ready++;
        end
        req = 1'b0;
        vectors++;
        if (starts !== 0 || not_ready !== 0) begin
            miscompares++;
            $display("FAIL illegal_funct3: starts=%0d busy_cycles=%0d required 0 0", starts, not_ready);
        end
    endtask

    task automatic test_back_to_back();
        int dc, nd, sc, ns;
        logic [31:0] r, o1, o2;
        run_op(3'b000, 32'h0000_0006, 32'h0000_0007, 1'b0, dc, nd, sc, ns, r, o1, o2);
        // run_op returns in the cycle after done_o, so the next call issues back-to-back.
        run_op(3'b000, 32'h0000_000B, 32'h0000_000D, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'h0000_008F || sc !== 1 || dc !== 36) begin
            miscompares++;
            $display("FAIL back_to_back: result=%h start_cycle=%0d done_cycle=%0d required 0000008F 1 36", r, sc, dc);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int dc, nd, sc, ns;
        logic [31:0] r, o1, o2;
        @(negedge clk);
        req = 1'b1; funct3 = 3'b011; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({ready, done, mul_start} !== 3'b100 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: ready/done/start=%b result=%h required 100 00000000", {ready, done, mul_start}, result);
        end
        for (int i = 0; i < 40; i++) begin
            mul_valid = (i == 3);
            mul_product = 64'hFFFF_FFFF_FFFF_FFFF;
            if (done) dones++;
            @(negedge clk);
        end
        mul_valid = 1'b0;
        vectors++;
        if (dones !== 0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: dones=%0d ready=%b required 0 1", dones, ready);
        end
        run_op(3'b011, 32'h0000_0003, 32'h0000_0005, 1'b0, dc, nd, sc, ns, r, o1, o2);
        vectors++;
        if (r !== 32'h0000_0000 || nd !== 1 || dc !== 36) begin
            miscompares++;
            $display("FAIL reset_mid_recover: result=%h dones=%0d done_cycle=%0d required 00000000 1 36", r, nd, dc);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_mulh();
        test_all_ones();
        test_busy_requests();
        test_illegal_funct3();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
